// File: rtl/wave_dds_gen_pkg.sv
// Shared types and constants for the DDS waveform generator.
package wave_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } wave_mode_e;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_e;

  localparam logic [8:0] AMP_UNITY = 9'd256;
  localparam real        PI        = 3.14159265358979323846;

  // Quarter-wave sine entry i, rounded to nearest, full scale 2^(out_w-1)-1.
  // Only ever evaluated at elaboration time to build the ROM contents.
  function automatic int sine_entry(input int i, input int lut_aw, input int out_w);
    real maxv;
    real ang;
    maxv = real'((1 << (out_w - 1)) - 1);
    ang  = (PI / 2.0) * real'(i) / real'(1 << lut_aw);
    return $rtoi(maxv * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/wave_dds_gen_if.sv
// Config handshake and sample stream of the DDS generator.
interface wave_dds_gen_if #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
);
  logic                      en;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [PHASE_W-1:0]        cfg_tune;
  logic [1:0]                cfg_mode;
  logic [8:0]                cfg_amp;
  logic signed [OUT_W-1:0]   wave_out;
  logic                      out_valid;
  logic                      phase_wrap;

  modport master (
    output en, cfg_valid, cfg_tune, cfg_mode, cfg_amp,
    input  cfg_ready, wave_out, out_valid, phase_wrap
  );

  modport slave (
    input  en, cfg_valid, cfg_tune, cfg_mode, cfg_amp,
    output cfg_ready, wave_out, out_valid, phase_wrap
  );
endinterface

// File: rtl/wave_dds_gen_rom.sv
// Quarter-wave sine magnitude ROM with registered read (stage A of the sine path).
module quarter_sine_rom
  import wave_pkg::*;
#(
  parameter int LUT_AW = 6,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [LUT_AW:0]   addr,
  output logic [OUT_W-2:0]  data
);
  localparam int DEPTH = (1 << LUT_AW) + 1;

  logic [OUT_W-2:0] rom_tbl [DEPTH];
  logic [OUT_W-2:0] data_d;
  logic [OUT_W-2:0] data_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam int VAL = sine_entry(gi, LUT_AW, OUT_W);
    assign rom_tbl[gi] = VAL[OUT_W-2:0];
  end

  // Read only on sample cycles so the entry stays aligned with the other shapes.
  always_comb begin
    data_d = data_q;
    if (rd_en) data_d = rom_tbl[addr];
  end

  // Read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/wave_dds_gen.sv
// DDS waveform generator: phase accumulator, shape stage A, amplitude stage B.
// Config changes are held pending and applied at phase wrap (or while idle).
//
// cfg state | meaning
// ----------+-----------------------------------------------
// CFG_IDLE  | no config pending, cfg_ready high
// CFG_PEND  | config captured, waits for wrap / en=0 / tune=0
module wave_dds_gen
  import wave_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int OUT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  wave_dds_gen_if.slave bus
);
  localparam logic signed [OUT_W-1:0] POS_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] NEG_MAX  = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
  localparam logic signed [OUT_W-1:0] NEG_FULL = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [LUT_AW:0]         QTR      = {1'b1, {LUT_AW{1'b0}}};

  // accumulator and config
  logic [PHASE_W-1:0] phase_d, phase_q;
  logic [PHASE_W:0]   sum;
  logic               carry;
  logic               wrap_d, wrap_q;
  cfg_state_e         cfg_st_d, cfg_st_q;
  logic               cfg_ready_d, cfg_ready_q;
  logic               cfg_accept, cfg_apply;
  logic [8:0]         amp_clamped;
  logic [PHASE_W-1:0] pend_tune_d, pend_tune_q, tune_act_d, tune_act_q;
  wave_mode_e         pend_mode_d, pend_mode_q, mode_act_d, mode_act_q;
  logic [8:0]         pend_amp_d, pend_amp_q, amp_act_d, amp_act_q;

  // stage A
  logic [1:0]              quad;
  logic [LUT_AW-1:0]       idx;
  logic [LUT_AW:0]         rom_addr;
  logic [OUT_W-2:0]        rom_data;
  logic signed [OUT_W-1:0] sq_raw, saw_full, saw_raw, tri_full, tri_raw;
  logic [OUT_W:0]          tri_u;
  logic [OUT_W-1:0]        tri_fold;
  logic                    sine_neg_d, sine_neg_q;
  logic signed [OUT_W-1:0] sq_d, sq_q, tri_d, tri_q, saw_d, saw_q;
  wave_mode_e              mode_a_d, mode_a_q;
  logic [8:0]              amp_a_d, amp_a_q;
  logic                    va_d, va_q;

  // stage B
  logic signed [OUT_W-1:0] sine_mag, sine_raw, raw;
  logic [OUT_W-1:0]        abs_raw, mag;
  logic [OUT_W+7:0]        prod;
  logic signed [OUT_W-1:0] scaled;
  logic signed [OUT_W-1:0] wave_d, wave_q;
  logic                    vb_d, vb_q;

  // Phase advance and wrap detection.
  always_comb begin
    sum     = {1'b0, phase_q} + {1'b0, tune_act_q};
    carry   = sum[PHASE_W];
    phase_d = bus.en ? sum[PHASE_W-1:0] : phase_q;
    wrap_d  = bus.en & carry;
  end

  // Config handshake: capture into pending, promote to active at a safe edge.
  // Apply is only possible from CFG_PEND, so it never shares an edge with accept.
  always_comb begin
    cfg_st_d    = cfg_st_q;
    pend_tune_d = pend_tune_q;
    pend_mode_d = pend_mode_q;
    pend_amp_d  = pend_amp_q;
    tune_act_d  = tune_act_q;
    mode_act_d  = mode_act_q;
    amp_act_d   = amp_act_q;
    amp_clamped = (bus.cfg_amp > AMP_UNITY) ? AMP_UNITY : bus.cfg_amp;
    cfg_accept  = bus.cfg_valid && (cfg_st_q == CFG_IDLE);
    cfg_apply   = (cfg_st_q == CFG_PEND) && (!bus.en || carry || (tune_act_q == '0));
    if (cfg_accept) begin
      cfg_st_d    = CFG_PEND;
      pend_tune_d = bus.cfg_tune;
      pend_mode_d = wave_mode_e'(bus.cfg_mode);
      pend_amp_d  = amp_clamped;
    end
    if (cfg_apply) begin
      cfg_st_d   = CFG_IDLE;
      tune_act_d = pend_tune_q;
      mode_act_d = pend_mode_q;
      amp_act_d  = pend_amp_q;
    end
    cfg_ready_d = (cfg_st_d == CFG_IDLE);
  end

  // Accumulator and config registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      wrap_q      <= 1'b0;
      cfg_st_q    <= CFG_IDLE;
      cfg_ready_q <= 1'b1;
      pend_tune_q <= '0;
      pend_mode_q <= MODE_SINE;
      pend_amp_q  <= AMP_UNITY;
      tune_act_q  <= '0;
      mode_act_q  <= MODE_SINE;
      amp_act_q   <= AMP_UNITY;
    end else begin
      phase_q     <= phase_d;
      wrap_q      <= wrap_d;
      cfg_st_q    <= cfg_st_d;
      cfg_ready_q <= cfg_ready_d;
      pend_tune_q <= pend_tune_d;
      pend_mode_q <= pend_mode_d;
      pend_amp_q  <= pend_amp_d;
      tune_act_q  <= tune_act_d;
      mode_act_q  <= mode_act_d;
      amp_act_q   <= amp_act_d;
    end
  end

  // Shapers: all computed from the current phase; the -full-scale code folds to -MAXV.
  always_comb begin
    quad     = phase_q[PHASE_W-1 -: 2];
    idx      = phase_q[PHASE_W-3 -: LUT_AW];
    rom_addr = quad[0] ? (QTR - {1'b0, idx}) : {1'b0, idx};
    sq_raw   = phase_q[PHASE_W-1] ? NEG_MAX : POS_MAX;
    saw_full = {~phase_q[PHASE_W-1], phase_q[PHASE_W-2 -: OUT_W-1]};
    saw_raw  = (saw_full == NEG_FULL) ? NEG_MAX : saw_full;
    tri_u    = phase_q[PHASE_W-1 -: OUT_W+1];
    // Descending half: 2^(OUT_W+1)-1-u is the bitwise complement of u.
    tri_fold = tri_u[OUT_W] ? ~tri_u[OUT_W-1:0] : tri_u[OUT_W-1:0];
    // Subtracting 2^(OUT_W-1) from an OUT_W-bit value flips its MSB.
    tri_full = {~tri_fold[OUT_W-1], tri_fold[OUT_W-2:0]};
    tri_raw  = (tri_full == NEG_FULL) ? NEG_MAX : tri_full;

    sine_neg_d = bus.en ? quad[1]    : sine_neg_q;
    sq_d       = bus.en ? sq_raw     : sq_q;
    tri_d      = bus.en ? tri_raw    : tri_q;
    saw_d      = bus.en ? saw_raw    : saw_q;
    mode_a_d   = bus.en ? mode_act_q : mode_a_q;
    amp_a_d    = bus.en ? amp_act_q  : amp_a_q;
    va_d       = bus.en;
  end

  quarter_sine_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .rd_en (bus.en),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  // Stage A registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sine_neg_q <= 1'b0;
      sq_q       <= '0;
      tri_q      <= '0;
      saw_q      <= '0;
      mode_a_q   <= MODE_SINE;
      amp_a_q    <= AMP_UNITY;
      va_q       <= 1'b0;
    end else begin
      sine_neg_q <= sine_neg_d;
      sq_q       <= sq_d;
      tri_q      <= tri_d;
      saw_q      <= saw_d;
      mode_a_q   <= mode_a_d;
      amp_a_q    <= amp_a_d;
      va_q       <= va_d;
    end
  end

  // Mode select and sign-magnitude scaling, truncating toward zero.
  always_comb begin
    sine_mag = {1'b0, rom_data};
    sine_raw = sine_neg_q ? -sine_mag : sine_mag;
    case (mode_a_q)
      MODE_SQUARE: raw = sq_q;
      MODE_TRI:    raw = tri_q;
      MODE_SAW:    raw = saw_q;
      default:     raw = sine_raw;
    endcase
    abs_raw = raw[OUT_W-1] ? -raw : raw;
    prod    = {8'b0, abs_raw} * {{(OUT_W-1){1'b0}}, amp_a_q};
    mag     = OUT_W'(prod >> 8);
    scaled  = raw[OUT_W-1] ? -mag : mag;
    wave_d  = va_q ? scaled : wave_q;
    vb_d    = va_q;
  end

  // Stage B registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave_q <= '0;
      vb_q   <= 1'b0;
    end else begin
      wave_q <= wave_d;
      vb_q   <= vb_d;
    end
  end

  assign bus.wave_out   = wave_q;
  assign bus.out_valid  = vb_q;
  assign bus.phase_wrap = wrap_q;
  assign bus.cfg_ready  = cfg_ready_q;

endmodule

// File: tb/tb_wave_dds_gen.sv
// Directed bench for wave_dds_gen: vector table plus handshake and reset sequences.
`timescale 1ns/1ps
module tb_wave_dds_gen;
  import wave_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wave_dds_gen_if #(.PHASE_W(16), .OUT_W(8)) bus ();

  wave_dds_gen #(.PHASE_W(16), .LUT_AW(6), .OUT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] tune;
    logic [8:0]  amp;
    int          exp [16];
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  int   sine8 [8];
  int   sq4 [4];

  task automatic chk(input string name, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Holds cfg_valid for one cycle starting at the current negedge.
  task automatic offer(input logic [1:0] m, input logic [15:0] t, input logic [8:0] a);
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = m;
    bus.cfg_tune  = t;
    bus.cfg_amp   = a;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_tune  = '0;
    bus.cfg_mode  = 2'd0;
    bus.cfg_amp   = 9'd256;

    sine8 = '{0, 90, 127, 90, 0, -90, -127, -90};
    sq4   = '{127, 127, -127, -127};

    vecs[0] = '{MODE_SINE,   16'h2000, 9'd256,
                '{0,90,127,90,0,-90,-127,-90, 0,90,127,90,0,-90,-127,-90}};
    vecs[1] = '{MODE_SQUARE, 16'h4000, 9'd256,
                '{127,127,-127,-127, 127,127,-127,-127, 127,127,-127,-127, 127,127,-127,-127}};
    vecs[2] = '{MODE_TRI,    16'h4000, 9'd256,
                '{-127,0,127,-1, -127,0,127,-1, -127,0,127,-1, -127,0,127,-1}};
    vecs[3] = '{MODE_SAW,    16'h1000, 9'd256,
                '{-127,-112,-96,-80,-64,-48,-32,-16,0,16,32,48,64,80,96,112}};
    vecs[4] = '{MODE_SINE,   16'h2000, 9'd128,
                '{0,45,63,45,0,-45,-63,-45, 0,45,63,45,0,-45,-63,-45}};
    vecs[5] = '{MODE_SINE,   16'h2000, 9'd0,
                '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0}};
    vecs[6] = '{MODE_SINE,   16'h2000, 9'd400,
                '{0,90,127,90,0,-90,-127,-90, 0,90,127,90,0,-90,-127,-90}};
    vecs[7] = '{MODE_SINE,   16'h1000, 9'd256,
                '{0,49,90,117,127,117,90,49,0,-49,-90,-117,-127,-117,-90,-49}};
    vecs[8] = '{MODE_TRI,    16'h4000, 9'd200,
                '{-99,0,99,0, -99,0,99,0, -99,0,99,0, -99,0,99,0}};

    // reset state while held
    repeat (2) @(negedge clk);
    chk("rst_wave",  $signed(bus.wave_out), 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ready", bus.cfg_ready, 1);
    chk("rst_wrap",  bus.phase_wrap, 0);
    rst = 1'b0;

    // phase_wrap cadence at tune 0x2000: every 8th en edge
    offer(MODE_SINE, 16'h2000, 9'd256);
    @(negedge clk);
    chk("wrap_cfg_ready", bus.cfg_ready, 1);
    bus.en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("wrap_k%0d", k), bus.phase_wrap, (k % 8 == 0) ? 1 : 0);
    end
    bus.en = 1'b0;

    // vector table: each from reset, config applied with en low, then 16 samples
    for (int v = 0; v < NV; v++) begin
      do_reset();
      offer(vecs[v].mode, vecs[v].tune, vecs[v].amp);
      @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int s = 0; s < 16; s++) begin
        chk($sformatf("v%0d_s%0d_wave", v, s), $signed(bus.wave_out), vecs[v].exp[s]);
        chk($sformatf("v%0d_s%0d_valid", v, s), bus.out_valid, 1);
        @(negedge clk);
      end
      bus.en = 1'b0;
    end

    // mid-period reconfig: sine 0x2000 running, square 0x4000 offered at k=3,
    // second offer at k=5 must be dropped
    do_reset();
    offer(MODE_SINE, 16'h2000, 9'd256);
    @(negedge clk);
    bus.en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk($sformatf("mid_k%0d_ready", k), bus.cfg_ready, (k >= 4 && k <= 7) ? 0 : 1);
      chk($sformatf("mid_k%0d_wrap", k), bus.phase_wrap,
          (k == 8 || k == 12 || k == 16) ? 1 : 0);
      if (k >= 2)
        chk($sformatf("mid_k%0d_wave", k), $signed(bus.wave_out),
            (k <= 9) ? sine8[k-2] : sq4[(k-10) % 4]);
      bus.cfg_valid = (k == 3 || k == 5);
      if (k == 3) begin
        bus.cfg_mode = MODE_SQUARE; bus.cfg_tune = 16'h4000; bus.cfg_amp = 9'd256;
      end
      if (k == 5) begin
        bus.cfg_mode = MODE_TRI; bus.cfg_tune = 16'h1000; bus.cfg_amp = 9'd100;
      end
    end

    // async reset with a config pending; pending must be discarded
    offer(MODE_SINE, 16'h1000, 9'd256);
    chk("arst_pre_ready", bus.cfg_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_wave",  $signed(bus.wave_out), 0);
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_ready", bus.cfg_ready, 1);
    chk("arst_wrap",  bus.phase_wrap, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("post_rst_%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("post_rst_%0d_wave", i), $signed(bus.wave_out), 0);
      chk($sformatf("post_rst_%0d_wrap", i), bus.phase_wrap, 0);
      chk($sformatf("post_rst_%0d_ready", i), bus.cfg_ready, 1);
      @(negedge clk);
    end
    bus.en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
